// File: rtl/gmii_pkg.sv
// rtl/gmii_pkg.sv - shared GMII RX constants, FSM state type and CRC helper
package gmii_pkg;

    localparam logic [7:0]  PREAMBLE      = 8'h55;
    localparam logic [7:0]  SFD           = 8'hD5;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam int          FCS_LEN       = 4;

    localparam int TRL_RXER = 0;
    localparam int TRL_CRC  = 1;
    localparam int TRL_OVF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } state_t;

    // The CRC engine shifts LSB-first, so its register is the bit-mirror of the textbook residue.
    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - byte-wide reflected CRC-32 (IEEE 802.3) with init and enable
module crc32_d8
    import gmii_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] nxt;

    // One byte of LSB-first CRC update; init wins over enable.
    always_comb begin
        nxt = crc_q;
        for (int i = 0; i < 8; i++) begin
            nxt = (nxt >> 1) ^ (((nxt[0] ^ data_i[i]) == 1'b1) ? CRC32_POLY : 32'h0);
        end
        crc_d = crc_q;
        if (init_i) begin
            crc_d = '1;
        end else if (en_i) begin
            crc_d = nxt;
        end
    end

    // CRC register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= '1;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/gmii2fifo9.sv
// rtl/gmii2fifo9.sv - GMII RX to 9-bit FIFO bridge; FCS check under GMII2FIFO9_FCS_CHECK_EN
module gmii2fifo9
    import gmii_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             gmii_rx_clk,
    input  logic             sys_rst_n,
    input  logic             gmii_rx_dv,
    input  logic             gmii_rx_er,
    input  logic [7:0]       gmii_rxd,
    input  logic             full,
    output logic [8:0]       din,
    output logic             wr_en,
    output logic             wr_clk,
    output logic [CNT_W-1:0] rx_frame_cnt,
    output logic [CNT_W-1:0] rx_drop_cnt
);

    localparam int DL_W = 8 * FCS_LEN;

    logic             dv_q, er_q;
    logic [7:0]       rxd_q;
    state_t           state_q, state_d;
    logic [DL_W-1:0]  dl_q, dl_d;
    logic [2:0]       dl_cnt_q, dl_cnt_d;
    logic             pay_q, pay_d;
    logic             rxer_q, rxer_d;
    logic             ovf_q, ovf_d;
    logic [8:0]       din_q, din_d;
    logic             wr_en_q, wr_en_d;
    logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d;
    logic [CNT_W-1:0] drp_cnt_q, drp_cnt_d;
    logic [7:0]       status;
    logic             crc_err;
    logic             trl_fire, trl_pend, pay_lost;

    // The output register doubles as the pending-trailer holder: a trailer stays put while full.
    assign trl_fire = wr_en_q & ~din_q[8] & ~full;
    assign trl_pend = wr_en_q & ~din_q[8] &  full;
    assign pay_lost = wr_en_q &  din_q[8] &  full;

`ifdef GMII2FIFO9_FCS_CHECK_EN
    logic        crc_init, crc_en;
    logic [31:0] crc_val;

    assign crc_init = (state_q == PRE) && dv_q && (rxd_q == SFD) && !trl_pend;
    assign crc_en   = (state_q == DATA) && dv_q;

    crc32_d8 u_crc (
        .clk_i  (gmii_rx_clk),
        .rst_ni (sys_rst_n),
        .init_i (crc_init),
        .en_i   (crc_en),
        .data_i (rxd_q),
        .crc_o  (crc_val)
    );

    assign crc_err = (bitrev32(crc_val) != CRC32_RESIDUE);
`else
    assign crc_err = 1'b0;
`endif

    // Input register stage for the GMII receive pins.
    always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dv_q  <= 1'b0;
            er_q  <= 1'b0;
            rxd_q <= 8'h00;
        end else begin
            dv_q  <= gmii_rx_dv;
            er_q  <= gmii_rx_er;
            rxd_q <= gmii_rxd;
        end
    end

    // Frame FSM next state, FCS delay line, trailer assembly and statistics.
    always_comb begin
        state_d   = state_q;
        dl_d      = dl_q;
        dl_cnt_d  = dl_cnt_q;
        pay_d     = pay_q;
        rxer_d    = rxer_q;
        ovf_d     = ovf_q | pay_lost;
        din_d     = din_q;
        wr_en_d   = trl_pend;
        frm_cnt_d = frm_cnt_q + (trl_fire ? CNT_W'(1) : CNT_W'(0));
        drp_cnt_d = drp_cnt_q;

        status           = 8'h00;
        status[TRL_RXER] = rxer_q | er_q;
        status[TRL_CRC]  = crc_err;
        status[TRL_OVF]  = ovf_q | pay_lost;

        case (state_q)
            IDLE: begin
                if (dv_q) begin
                    if (rxd_q == PREAMBLE) begin
                        state_d = PRE;
                    end else begin
                        state_d   = DROP;
                        drp_cnt_d = drp_cnt_q + CNT_W'(1);
                    end
                end
            end
            PRE: begin
                if (!dv_q) begin
                    state_d   = IDLE;
                    drp_cnt_d = drp_cnt_q + CNT_W'(1);
                end else if ((rxd_q == SFD) && !trl_pend) begin
                    state_d  = DATA;
                    dl_d     = '0;
                    dl_cnt_d = 3'd0;
                    pay_d    = 1'b0;
                    rxer_d   = 1'b0;
                    ovf_d    = 1'b0;
                end else if (rxd_q != PREAMBLE) begin
                    state_d   = DROP;
                    drp_cnt_d = drp_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                rxer_d = rxer_q | er_q;
                if (dv_q) begin
                    dl_d = {dl_q[DL_W-9:0], rxd_q};
                    if (dl_cnt_q == 3'(FCS_LEN)) begin
                        pay_d   = 1'b1;
                        din_d   = {1'b1, dl_q[DL_W-1 -: 8]};
                        wr_en_d = 1'b1;
                    end else begin
                        dl_cnt_d = dl_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = IDLE;
                    if (pay_q) begin
                        din_d   = {1'b0, status};
                        wr_en_d = 1'b1;
                    end else begin
                        drp_cnt_d = drp_cnt_q + CNT_W'(1);
                    end
                end
            end
            DROP: begin
                if (!dv_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, delay line, frame flags, output register and counters.
    always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            dl_q      <= '0;
            dl_cnt_q  <= 3'd0;
            pay_q     <= 1'b0;
            rxer_q    <= 1'b0;
            ovf_q     <= 1'b0;
            din_q     <= 9'h000;
            wr_en_q   <= 1'b0;
            frm_cnt_q <= '0;
            drp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dl_q      <= dl_d;
            dl_cnt_q  <= dl_cnt_d;
            pay_q     <= pay_d;
            rxer_q    <= rxer_d;
            ovf_q     <= ovf_d;
            din_q     <= din_d;
            wr_en_q   <= wr_en_d;
            frm_cnt_q <= frm_cnt_d;
            drp_cnt_q <= drp_cnt_d;
        end
    end

    assign din          = din_q;
    assign wr_en        = wr_en_q & ~full;
    assign wr_clk       = gmii_rx_clk;
    assign rx_frame_cnt = frm_cnt_q;
    assign rx_drop_cnt  = drp_cnt_q;

endmodule

// File: tb/tb_gmii2fifo9.sv
// tb/tb_gmii2fifo9.sv - self-checking bench for gmii2fifo9
module tb_gmii2fifo9;

    localparam int CNT_W = 4;
`ifdef GMII2FIFO9_FCS_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             dv    = 1'b0;
    logic             er    = 1'b0;
    logic             full  = 1'b0;
    logic [7:0]       rxd   = 8'h00;
    logic [8:0]       din;
    logic             wr_en;
    logic             wr_clk;
    logic [CNT_W-1:0] frm_cnt;
    logic [CNT_W-1:0] drp_cnt;

    gmii2fifo9 #(.CNT_W(CNT_W)) dut (
        .gmii_rx_clk  (clk),
        .sys_rst_n    (rst_n),
        .gmii_rx_dv   (dv),
        .gmii_rx_er   (er),
        .gmii_rxd     (rxd),
        .full         (full),
        .din          (din),
        .wr_en        (wr_en),
        .wr_clk       (wr_clk),
        .rx_frame_cnt (frm_cnt),
        .rx_drop_cnt  (drp_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0, viol = 0;
    int b0 = 0, full_lo = 1, full_hi = 0, exp_frames = 0, exp_drops = 0;
    logic [8:0] got_d[$], exp_d[$];
    int         got_c[$], exp_c[$];
    logic [7:0] pay[$], fb[$];

    // Record every FIFO write with the edge number after which it was presented.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            got_d.push_back(din);
            got_c.push_back(cyc);
            if (full !== 1'b0) viol++;
        end
    end

    function automatic logic [31:0] crc32_of(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build(input int p, input bit rnd, input bit corrupt);
        logic [31:0] fcs;
        pay.delete();
        for (int i = 0; i < p; i++) pay.push_back(rnd ? 8'($urandom) : 8'(i));
        fcs = crc32_of(pay);
        fb = pay;
        for (int k = 0; k < 4; k++) fb.push_back(fcs[8*k +: 8]);
        if (corrupt) fb[fb.size()-1] = ~fb[fb.size()-1];
    endtask

    // Expected writes: payload j is presented 6 edges after it was on the bus, unless full is high then;
    // the trailer follows the last payload slot and waits out any full cycles.
    task automatic model(input int p, input bit er_hit, input bit corrupt);
        bit ovf = 1'b0;
        int c, t;
        exp_d.delete();
        exp_c.delete();
        if (p == 0) begin
            exp_drops++;
            return;
        end
        for (int j = 0; j < p; j++) begin
            c = b0 + j + 6;
            if (c >= full_lo && c <= full_hi) ovf = 1'b1;
            else begin
                exp_d.push_back({1'b1, pay[j]});
                exp_c.push_back(c);
            end
        end
        t = b0 + p + 6;
        while (t >= full_lo && t <= full_hi) t++;
        exp_d.push_back({4'b0000, 2'b00, ovf, CRC_ON & corrupt, er_hit});
        exp_c.push_back(t);
        exp_frames++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        full = (cyc >= full_lo) && (cyc <= full_hi);
    endtask

    task automatic send(input logic [7:0] sfd, input int er_idx, input int ifg);
        for (int i = 0; i < 7; i++) begin
            step(); dv = 1'b1; rxd = 8'h55; er = 1'b0;
        end
        step(); rxd = sfd;
        for (int i = 0; i < fb.size(); i++) begin
            step(); rxd = fb[i]; er = (i == er_idx);
        end
        step(); dv = 1'b0; er = 1'b0; rxd = 8'h00;
        repeat (ifg) step();
    endtask

    task automatic test_reset();
        repeat (3) step();
        total++; if (din !== 9'h000) begin bad++; $display("FAIL rst_din: got %h expected 000", din); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %b expected 0", wr_en); end
        total++; if (frm_cnt !== '0) begin bad++; $display("FAIL rst_frm_cnt: got %0d expected 0", frm_cnt); end
        total++; if (drp_cnt !== '0) begin bad++; $display("FAIL rst_drp_cnt: got %0d expected 0", drp_cnt); end
        total++; if (wr_clk !== 1'b1) begin bad++; $display("FAIL wr_clk: got %b expected 1", wr_clk); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_frame(input string name, input int p, input bit rnd, input bit corrupt,
                              input int er_idx, input int lo_off, input int hi_off);
        build(p, rnd, corrupt);
        b0 = cyc + 9;
        full_lo = (hi_off >= lo_off) ? b0 + lo_off : 1;
        full_hi = (hi_off >= lo_off) ? b0 + hi_off : 0;
        model(p, (er_idx >= 0) && (er_idx < p + 4), corrupt);
        got_d.delete(); got_c.delete();
        send(8'hD5, er_idx, 16);
        total++;
        if (got_d.size() !== exp_d.size()) begin
            bad++; $display("FAIL %s_count: got %0d writes expected %0d", name, got_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                total++;
                if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i]) begin
                    bad++; $display("FAIL %s_w%0d: got %h@%0d expected %h@%0d", name, i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
                end
            end
        end
        total++; if (frm_cnt !== CNT_W'(exp_frames)) begin bad++; $display("FAIL %s_frm_cnt: got %0d expected %0d", name, frm_cnt, CNT_W'(exp_frames)); end
        total++; if (drp_cnt !== CNT_W'(exp_drops)) begin bad++; $display("FAIL %s_drp_cnt: got %0d expected %0d", name, drp_cnt, CNT_W'(exp_drops)); end
        full_lo = 1; full_hi = 0;
    endtask

    task automatic test_full();
        viol = 0;
        test_frame("full_pay", 60, 1'b0, 1'b0, -1, 16, 18);
        test_frame("full_trl", 60, 1'b0, 1'b0, -1, 66, 70);
        total++; if (viol !== 0) begin bad++; $display("FAIL full_wr_en: got %0d writes under full expected 0", viol); end
    endtask

    task automatic test_drop();
        fb.delete();
        fb.push_back(8'h01); fb.push_back(8'h02); fb.push_back(8'h03);
        exp_drops++;
        got_d.delete(); got_c.delete();
        send(8'hD5, -1, 16);
        total++; if (got_d.size() !== 0) begin bad++; $display("FAIL runt_writes: got %0d expected 0", got_d.size()); end
        total++; if (drp_cnt !== CNT_W'(exp_drops)) begin bad++; $display("FAIL runt_drp_cnt: got %0d expected %0d", drp_cnt, CNT_W'(exp_drops)); end
        build(60, 1'b0, 1'b0);
        exp_drops++;
        send(8'h5D, -1, 16);
        total++; if (got_d.size() !== 0) begin bad++; $display("FAIL badsfd_writes: got %0d expected 0", got_d.size()); end
        total++; if (drp_cnt !== CNT_W'(exp_drops)) begin bad++; $display("FAIL badsfd_drp_cnt: got %0d expected %0d", drp_cnt, CNT_W'(exp_drops)); end
        total++; if (frm_cnt !== CNT_W'(exp_frames)) begin bad++; $display("FAIL badsfd_frm_cnt: got %0d expected %0d", frm_cnt, CNT_W'(exp_frames)); end
    endtask

    task automatic test_random();
        int p, er_idx, lo, hi;
        for (int n = 0; n < 14; n++) begin
            p = $urandom_range(0, 30);
            er_idx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, p + 3) : -1;
            lo = $urandom_range(4, p + 8);
            hi = ($urandom_range(0, 1) == 1) ? lo + $urandom_range(0, 4) : lo - 1;
            test_frame("rand", p, 1'b1, 1'($urandom_range(0, 1)), er_idx, lo, hi);
        end
    endtask

    task automatic test_reset_mid();
        build(60, 1'b0, 1'b0);
        b0 = cyc + 9;
        got_d.delete(); got_c.delete();
        for (int i = 0; i < 7; i++) begin
            step(); dv = 1'b1; rxd = 8'h55;
        end
        step(); rxd = 8'hD5;
        for (int i = 0; i < 30; i++) begin
            step(); rxd = fb[i];
        end
        step();
        #2;
        rst_n = 1'b0; dv = 1'b0; rxd = 8'h00;
        #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rstmid_wr_en: got %b expected 0", wr_en); end
        step(); step();
        rst_n = 1'b1;
        exp_frames = 0; exp_drops = 0;
        step();
        total++; if (frm_cnt !== '0) begin bad++; $display("FAIL rstmid_frm_cnt: got %0d expected 0", frm_cnt); end
        total++; if (drp_cnt !== '0) begin bad++; $display("FAIL rstmid_drp_cnt: got %0d expected 0", drp_cnt); end
        total++; if (got_d.size() !== 24) begin bad++; $display("FAIL rstmid_count: got %0d writes expected 24", got_d.size()); end
        foreach (got_d[i]) begin
            total++;
            if (got_d[i] !== {1'b1, 8'(i)}) begin bad++; $display("FAIL rstmid_w%0d: got %h expected %h", i, got_d[i], {1'b1, 8'(i)}); end
        end
        repeat (12) step();
        test_frame("after_rst", 60, 1'b1, 1'b0, -1, 0, -1);
    endtask

    initial begin
        test_reset();
        test_frame("good", 60, 1'b0, 1'b0, -1, 0, -1);
        test_frame("fcs", 60, 1'b0, 1'b1, -1, 0, -1);
        test_frame("rx_err", 60, 1'b0, 1'b0, 20, 0, -1);
        test_full();
        test_drop();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
